// File: rtl/gemm_pkg.sv
// Shared types and helpers for the streaming GEMM engine: FSM encoding,
// index sizing and the saturation limits used by the MAC datapath.
package gemm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      MAC    = 3'd3,
      OUT    = 3'd4
   } gemm_state_e;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Limits are returned as 64-bit signed values and truncated by the caller
   // to the accumulator width, so they hold for element widths up to 32 bits.
   function automatic logic signed [63:0] sat_hi(input int dw, input bit is_signed);
      if (is_signed) return (64'sd1 <<< (dw - 1)) - 64'sd1;
      return (64'sd1 <<< dw) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_lo(input int dw, input bit is_signed);
      if (is_signed) return -(64'sd1 <<< (dw - 1));
      return 64'sd0;
   endfunction

endpackage

// File: rtl/gemm_mac.sv
// Single multiply-accumulate lane: extends operands per SIGNED, accumulates
// with clear-on-first, and presents the running sum saturated to DATA_WIDTH.
module gemm_mac
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SIGNED     = 1,
   parameter int ACC_WIDTH  = 34
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  first,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] sat_data,
   output logic                  sat_flag
);

   localparam logic [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(DATA_WIDTH, SIGNED != 0));
   localparam logic [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(DATA_WIDTH, SIGNED != 0));

   logic signed [DATA_WIDTH:0]  a_x;
   logic signed [DATA_WIDTH:0]  b_x;
   logic signed [ACC_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]        acc;
   logic [ACC_WIDTH-1:0]        acc_sum;
   logic                        over_hi;
   logic                        under_lo;

   // One extra top bit turns both modes into a signed multiply; the true
   // product always fits ACC_WIDTH, so truncation of the wide result is exact.
   always_comb begin
      a_x      = {(SIGNED != 0) && a[DATA_WIDTH-1], a};
      b_x      = {(SIGNED != 0) && b[DATA_WIDTH-1], b};
      prod     = a_x * b_x;
      acc_sum  = (first ? '0 : acc) + prod;
      over_hi  = 1'b0;
      under_lo = 1'b0;
      if (SIGNED != 0) begin
         over_hi  = $signed(acc_sum) > $signed(SAT_HI);
         under_lo = $signed(acc_sum) < $signed(SAT_LO);
      end else begin
         over_hi  = acc_sum > SAT_HI;
      end
      sat_flag = over_hi || under_lo;
      if (over_hi)       sat_data = SAT_HI[DATA_WIDTH-1:0];
      else if (under_lo) sat_data = SAT_LO[DATA_WIDTH-1:0];
      else               sat_data = acc_sum[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  acc <= '0;
      else if (en)   acc <= acc_sum;
   end

endmodule

// File: rtl/gemm_stream.sv
// Streaming C = A x B engine: loads A then B row-major, computes each C
// element with N MAC cycles and returns it saturated, row-major.
module gemm_stream
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int MATRIX_SIZE = 4,
   parameter int SIGNED      = 1,
   parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(MATRIX_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output gemm_state_e           state
);

   localparam int N  = MATRIX_SIZE;
   localparam int NN = N * N;
   localparam int IW = idx_width(N);
   localparam int AW = idx_width(NN);

   gemm_state_e           state_nxt;
   logic [AW-1:0]         ld_idx;
   logic [IW-1:0]         row_i, col_j, k_idx;
   logic [AW-1:0]         a_addr, b_addr;
   logic [DATA_WIDTH-1:0] a_mem [NN];
   logic [DATA_WIDTH-1:0] b_mem [NN];
   logic [DATA_WIDTH-1:0] mac_data;
   logic                  mac_sat;
   logic                  in_fire, ld_last, k_last, j_last, i_last;

   // Handshake: a word moves on a rising edge where valid and ready are both
   // high; ready never depends on valid, and out_valid/out_data hold until taken.
   assign in_fire = in_valid && in_ready;
   assign ld_last = (ld_idx == AW'(NN - 1));
   assign k_last  = (k_idx == IW'(N - 1));
   assign j_last  = (col_j == IW'(N - 1));
   assign i_last  = (row_i == IW'(N - 1));
   assign a_addr  = AW'(int'(row_i) * N + int'(k_idx));
   assign b_addr  = AW'(int'(k_idx) * N + int'(col_j));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD_A;
         LOAD_A:  if (in_fire && ld_last) state_nxt = LOAD_B;
         LOAD_B:  if (in_fire && ld_last) state_nxt = MAC;
         MAC:     if (k_last) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = (i_last && j_last) ? IDLE : MAC;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      in_ready  = (state == LOAD_A) || (state == LOAD_B);
      out_valid = (state == OUT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_idx   <= '0;
         row_i    <= '0;
         col_j    <= '0;
         k_idx    <= '0;
         out_data <= '0;
         out_sat  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               ld_idx <= '0;
               row_i  <= '0;
               col_j  <= '0;
               k_idx  <= '0;
            end
            LOAD_A, LOAD_B: if (in_fire) ld_idx <= ld_last ? '0 : ld_idx + AW'(1);
            MAC: begin
               k_idx <= k_last ? '0 : k_idx + IW'(1);
               if (k_last) begin
                  out_data <= mac_data;
                  out_sat  <= mac_sat;
               end
            end
            OUT: if (out_ready) begin
               col_j <= j_last ? '0 : col_j + IW'(1);
               if (j_last) row_i <= i_last ? '0 : row_i + IW'(1);
               done <= j_last && i_last;
            end
            default: ;
         endcase
      end
   end

   // Operand storage carries no reset; contents are rewritten by every job.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         if (state == LOAD_A) a_mem[ld_idx] <= in_data;
         else                 b_mem[ld_idx] <= in_data;
      end
   end

   gemm_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .SIGNED    (SIGNED),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == MAC),
      .first   (k_idx == '0),
      .a       (a_mem[a_addr]),
      .b       (b_mem[b_addr]),
      .sat_data(mac_data),
      .sat_flag(mac_sat)
   );

endmodule

// File: tb/tb_gemm_stream.sv
// Directed bench for gemm_stream: a 4x4 and a 2x2 signed instance share the
// operand/result stimulus; vectors are applied from a table plus corner sequences.
module tb_gemm_stream;
   import gemm_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        start, sel2, in_valid, out_ready;
   logic [15:0] in_data;
   logic        start4, start2;
   assign start4 = start & ~sel2;
   assign start2 = start & sel2;

   logic busy4, done4, in_ready4, out_valid4, out_sat4;
   logic busy2, done2, in_ready2, out_valid2, out_sat2;
   logic [15:0] out_data4, out_data2;
   gemm_state_e state4, state2;

   gemm_stream #(.DATA_WIDTH(16), .MATRIX_SIZE(4), .SIGNED(1)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .busy(busy4), .done(done4),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .out_sat(out_sat4), .state(state4));

   gemm_stream #(.DATA_WIDTH(16), .MATRIX_SIZE(2), .SIGNED(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_sat(out_sat2), .state(state2));

   logic        c_busy, c_done, c_in_ready, c_out_valid, c_out_sat;
   logic [15:0] c_out_data;
   gemm_state_e c_state;
   assign c_busy      = sel2 ? busy2      : busy4;
   assign c_done      = sel2 ? done2      : done4;
   assign c_in_ready  = sel2 ? in_ready2  : in_ready4;
   assign c_out_valid = sel2 ? out_valid2 : out_valid4;
   assign c_out_sat   = sel2 ? out_sat2   : out_sat4;
   assign c_out_data  = sel2 ? out_data2  : out_data4;
   assign c_state     = sel2 ? state2     : state4;

   typedef struct packed {
      logic         n2;
      logic [255:0] a;
      logic [255:0] b;
      logic [255:0] exp_c;
      logic [15:0]  exp_sat;
   } vec_t;

   vec_t vecs [7];
   int   n_checks;
   int   n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pk4(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
      logic [255:0] r;
      r = '0;
      r[63:0] = {e3, e2, e1, e0};
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outs4"}, 32'({busy4, done4, in_ready4, out_valid4, out_sat4, out_data4}), 32'h0);
      check({tag, "_state4"}, 32'(state4), 32'(IDLE));
      check({tag, "_outs2"}, 32'({busy2, done2, in_ready2, out_valid2, out_sat2, out_data2}), 32'h0);
      check({tag, "_state2"}, 32'(state2), 32'(IDLE));
   endtask

   // Runs one job; abort_at >= 0 pulls reset while that element is in MAC.
   task automatic run_job(input vec_t v, input bit gaps, input bit rnd_ready,
                          input bit poke, input int abort_at, input string tag);
      int n, total, idx, got, cyc, lat, dones, guard;
      logic [16:0] held;
      bit holding;
      logic rdy;
      n     = v.n2 ? 2 : 4;
      total = 2 * n * n;
      sel2  = v.n2;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      check({tag, "_idle_in_ready"}, 32'(c_in_ready), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, 32'(c_busy), 32'd1);
      idx = 0;
      cyc = 0;
      while (idx < total && cyc < 1000) begin
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = (idx < n*n) ? v.a[idx*16 +: 16] : v.b[(idx - n*n)*16 +: 16];
         if (in_valid && c_in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, "_load_words"}, 32'(idx), 32'(total));
      // The cycle of the last B handshake is cycle 0; this negedge is cycle 1.
      lat = 1;
      while (!c_out_valid && lat < 50) begin
         start = (poke && lat == 2);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, "_first_out_cycle"}, 32'(lat), 32'(n + 1));
      got = 0;
      dones = 0;
      holding = 1'b0;
      held = '0;
      guard = 0;
      while (got < n*n && guard < 2000) begin
         if (abort_at == got && !c_out_valid) begin
            reset_n = 1'b0;
            #1;
            check({tag, "_abort_outs"},
                  32'({c_busy, c_done, c_in_ready, c_out_valid, c_out_sat, c_out_data}), 32'h0);
            check({tag, "_abort_state"}, 32'(c_state), 32'(IDLE));
            check({tag, "_abort_no_done"}, 32'(dones), 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            out_ready = 1'b0;
            repeat (4) @(negedge clk);
            check({tag, "_abort_stays_idle"}, 32'({c_busy, c_done, c_out_valid}), 32'h0);
            return;
         end
         rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         if (c_done) dones++;
         if (c_out_valid) begin
            if (holding) check($sformatf("%s_hold_%0d", tag, got), 32'({c_out_sat, c_out_data}), 32'(held));
            if (rdy) begin
               check($sformatf("%s_data_%0d", tag, got), 32'(c_out_data), 32'(v.exp_c[got*16 +: 16]));
               check($sformatf("%s_sat_%0d", tag, got), 32'(c_out_sat), 32'(v.exp_sat[got]));
               got++;
               holding = 1'b0;
            end else begin
               holding = 1'b1;
               held = {c_out_sat, c_out_data};
            end
         end
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b0;
      check({tag, "_elements"}, 32'(got), 32'(n * n));
      check({tag, "_early_done"}, 32'(dones), 32'd0);
      check({tag, "_done_pulse"}, 32'(c_done), 32'd1);
      check({tag, "_busy_fall"}, 32'(c_busy), 32'd0);
      dones = 0;
      cyc = 0;
      repeat (8) begin
         @(negedge clk);
         if (c_done) dones++;
         if (c_busy) cyc++;
      end
      check({tag, "_single_done"}, 32'(dones), 32'd0);
      check({tag, "_idle_after"}, 32'(cyc), 32'd0);
   endtask

   initial begin
      logic [255:0] ta, tb, tc;
      n_checks  = 0;
      n_fail    = 0;
      start     = 1'b0;
      sel2      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      reset_n   = 1'b0;

      ta = '0; tb = '0; tc = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ta[(4*r + c)*16 +: 16] = (r == c) ? 16'd1 : 16'd0;
            tb[(4*r + c)*16 +: 16] = 16'(4*r + c);
            tc[(4*r + c)*16 +: 16] = 16'(4*r + c);
         end
      end
      vecs[0] = '{n2: 1'b0, a: ta, b: tb, exp_c: tc, exp_sat: 16'h0000};
      vecs[1] = '{n2: 1'b1, a: pk4(16'd1, 16'd2, 16'd3, 16'd4), b: pk4(16'd5, 16'd6, 16'd7, 16'd8),
                  exp_c: pk4(16'd19, 16'd22, 16'd43, 16'd50), exp_sat: 16'h0000};
      vecs[2] = '{n2: 1'b0, a: {16{16'h7FFF}}, b: {16{16'h7FFF}}, exp_c: {16{16'h7FFF}}, exp_sat: 16'hFFFF};
      vecs[3] = '{n2: 1'b0, a: {16{16'h8000}}, b: {16{16'h7FFF}}, exp_c: {16{16'h8000}}, exp_sat: 16'hFFFF};
      vecs[4] = '{n2: 1'b1, a: pk4(16'hFFFF, 16'd2, 16'd3, 16'hFFFC), b: pk4(16'd5, 16'd6, 16'd7, 16'd8),
                  exp_c: pk4(16'd9, 16'd10, 16'hFFF3, 16'hFFF2), exp_sat: 16'h0000};
      vecs[5] = '{n2: 1'b1, a: pk4(16'h8000, 16'd0, 16'd0, 16'h7FFF), b: pk4(16'd1, 16'd0, 16'd0, 16'd1),
                  exp_c: pk4(16'h8000, 16'd0, 16'd0, 16'h7FFF), exp_sat: 16'h0000};
      vecs[6] = '{n2: 1'b1, a: pk4(16'h7FFF, 16'd1, 16'h8000, 16'hFFFF), b: pk4(16'd1, 16'd0, 16'd1, 16'd0),
                  exp_c: pk4(16'h7FFF, 16'd0, 16'h8000, 16'd0), exp_sat: 16'h0005};

      repeat (3) @(negedge clk);
      check_reset_outputs("rst_held");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_released");

      for (int v = 0; v < 7; v++) run_job(vecs[v], 1'b0, 1'b0, 1'b0, -1, $sformatf("vec%0d", v));

      run_job(vecs[1], 1'b1, 1'b1, 1'b0, -1, "stall_hand");
      run_job(vecs[4], 1'b1, 1'b1, 1'b0, -1, "stall_mixed");
      run_job(vecs[2], 1'b1, 1'b1, 1'b0, -1, "stall_sat4");
      run_job(vecs[1], 1'b0, 1'b0, 1'b1, -1, "start_busy");
      run_job(vecs[0], 1'b0, 1'b0, 1'b0, 2, "abort");
      run_job(vecs[0], 1'b0, 1'b0, 1'b0, -1, "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gemm_stream.md
# gemm_stream

Parametrised streaming matrix-multiply engine that computes C = A × B for square MATRIX_SIZE × MATRIX_SIZE operands. Operands arrive row-major over a single valid/ready input stream and are held in internal register arrays. The engine computes with one multiply-accumulate per cycle into a wide accumulator. It returns saturated C elements row-major over a valid/ready output stream, and sits between the operand DMA and the result writeback path of the algorithm datapath.

## Interface
- DATA_WIDTH, 16: operand and result element width.
- MATRIX_SIZE, 4: matrix dimension N (≥ 2).
- SIGNED, 1: 1 = two's-complement operands and results; 0 = unsigned.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MATRIX_SIZE): accumulator width, sized so accumulation cannot overflow.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last C element handshake.
- in_valid  in  1  operand word valid.
- in_ready  out  1  engine accepts an operand word (LOAD_A/LOAD_B only).
- in_data  in  DATA_WIDTH  operand word: N² A words, then N² B words.
- out_valid  out  1  C element valid.
- out_ready  in  1  downstream accepts C element.
- out_data  out  DATA_WIDTH  saturated C[i][j].
- out_sat  out  1  qualifies out_data: the element was clipped.

## Operation
- States: IDLE → LOAD_A → LOAD_B → MAC → OUT → (MAC | IDLE).
- IDLE: when start=1, clear the indices and go to LOAD_A.
- LOAD_A: in_ready=1. Each in_valid&in_ready writes A[idx]. After N² words, go to LOAD_B.
- LOAD_B: same as LOAD_A for B. After N² words, set i=j=0 and go to MAC.
- MAC: acc = Σk A[i][k]·B[k][j]. One product per cycle, k = 0..N−1. The first cycle loads the product and does not add to a stale acc. After k=N−1, go to OUT.
- OUT: out_valid=1 and out_data/out_sat are registered and held stable until out_ready.
  - On handshake, advance j. On j wrap, advance i.
  - After the last element (i=j=N−1), pulse done and go to IDLE. Otherwise go to MAC.
- Products and the accumulator are sign- or zero-extended to ACC_WIDTH according to SIGNED.
- Saturation when SIGNED=1:
  - acc > 2^(DW−1)−1 → 2^(DW−1)−1 with out_sat=1.
  - acc < −2^(DW−1) → −2^(DW−1) with out_sat=1.
- Saturation when SIGNED=0: acc > 2^DW−1 → 2^DW−1 with out_sat=1.
- start asserted while busy is ignored and does not queue.
- in_valid outside the LOAD states is ignored (in_ready=0).

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, state=IDLE. A/B contents are don't-care.
- Reset asserted mid-job aborts immediately. No done pulse; a new start is needed after release.
- Load phase: 2N² cycles minimum; each in_valid stall adds one cycle.
- Per C element: N MAC cycles plus ≥1 OUT cycle. Total compute ≥ N²(N+1) cycles with out_ready held high.
- done rises on the cycle after the final output handshake. busy falls in the same cycle.
- The first out_valid appears N+1 cycles after the last B word is accepted.

## Structure
- Package gemm_pkg: state enum (IDLE, LOAD_A, LOAD_B, MAC, OUT), an index-width constant function, and saturation-limit functions parametrised by width and SIGNED.
- Sub-module gemm_mac: multiply, extend, accumulate with clear-on-first, and saturate to DATA_WIDTH with a sat flag. The top level owns the FSM, the index counters and the operand arrays.

## Test plan
- Identity: N=4, A=I, B[r][c]=4r+c → outputs 0..15 in order, out_sat=0, done after 16 handshakes.
- Hand-computed: N=2, A={{1,2},{3,4}}, B={{5,6},{7,8}} → 19,22,43,50.
- Signed saturation: N=4, SIGNED=1, all A=B=16'h7FFF → every out_data=16'h7FFF, out_sat=1. All A=16'h8000 with all B=16'h7FFF → 16'h8000, out_sat=1.
- Backpressure and stalls:
  - Random in_valid gaps and random out_ready → same 19,22,43,50 result.
  - out_data is stable while out_valid is high and out_ready is low.
- start during busy: pulse start mid-MAC → no effect, exactly one done.
- Reset mid-MAC: assert reset_n=0 during the third element → all outputs return to reset values. A fresh job after release gives correct results.
